// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - framed serial-to-byte receiver with valid/ready holding register.
// Define PARITY_EN to receive and check an even-parity bit between the data bits and the stop bit.
module serial_to_parallel #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       bitn, bitn_d;
  logic [7:0]       shift, shift_d;
  logic [7:0]       data_d;
  logic             valid_d, err_d, ovr_d;
  logic             good_stop;

`ifdef PARITY_EN
  logic par_err, par_d;
  assign good_stop = ~data_in & ~par_err;
`else
  assign good_stop = ~data_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shift     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bitn      <= bitn_d;
      shift     <= shift_d;
      data_out  <= data_d;
      valid     <= valid_d;
      frame_err <= err_d;
      overrun   <= ovr_d;
`ifdef PARITY_EN
      par_err   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bitn_d  = bitn;
    shift_d = shift;
    data_d  = data_out;
    valid_d = valid & ~ready;
    err_d   = 1'b0;
    ovr_d   = overrun;
`ifdef PARITY_EN
    par_d   = par_err;
`endif
    case (state)
      IDLE: begin
        if (data_in) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // A start bit that has gone low by mid-bit is a glitch, not a frame.
        if (cnt == HALF) begin
          cnt_d   = '0;
          bitn_d  = '0;
          state_d = data_in ? DATA : IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          shift_d = {shift[6:0], data_in};
          bitn_d  = bitn + 4'd1;
          cnt_d   = '0;
          if (bitn == LAST_BIT) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (cnt == LAST) begin
          par_d   = ^{shift, data_in};
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        // Leaving at the mid-stop sample lets a following start bit be caught from IDLE.
        if (cnt == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (good_stop) begin
            if (!valid || ready) begin
              data_d  = shift;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb/tb_serial_to_parallel.sv - directed-vector bench for serial_to_parallel at CLKS_PER_BIT 4 and 2.
module tb_serial_to_parallel;

`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int VC  = 4 * NB - 1;
  localparam int VC2 = 2 * NB;

  logic       clk = 1'b0;
  logic       rst, din4, din2, rdy4, rdy2;
  logic [7:0] d4, d2;
  logic       v4, b4, e4, o4, v2, b2, e2, o2;

  always #5 clk = ~clk;

  serial_to_parallel #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u4 (
    .clk(clk), .rst(rst), .data_in(din4), .data_out(d4), .valid(v4),
    .ready(rdy4), .busy(b4), .frame_err(e4), .overrun(o4)
  );

  serial_to_parallel #(.CLKS_PER_BIT(2), .DATA_BITS(8)) u2 (
    .clk(clk), .rst(rst), .data_in(din2), .data_out(d2), .valid(v2),
    .ready(rdy2), .busy(b2), .frame_err(e2), .overrun(o2)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic       wave  [0:255];
  int         wlen = 0;
  int         plen = 0;
  logic       v_log [0:255];
  logic       e_log [0:255];
  logic       b_log [0:255];
  logic       o_log [0:255];
  logic [7:0] d_log [0:255];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      wave[wlen] = v;
      wlen++;
    end
  endtask

  task automatic add_frame(input int cpb, input logic [7:0] b, input logic stop_bit, input logic bad_par);
    push(1'b1, cpb);
    for (int i = 7; i >= 0; i--) push(b[i], cpb);
`ifdef PARITY_EN
    push((^b) ^ bad_par, cpb);
`endif
    push(stop_bit, cpb);
  endtask

  // Cycle t of the wave is driven just after an edge and logged at the following negedge.
  task automatic play(input bit on2);
    for (int t = 0; t < wlen; t++) begin
      if (on2) din2 = wave[t];
      else     din4 = wave[t];
      @(negedge clk);
      v_log[t] = on2 ? v2 : v4;
      e_log[t] = on2 ? e2 : e4;
      b_log[t] = on2 ? b2 : b4;
      o_log[t] = on2 ? o2 : o4;
      d_log[t] = on2 ? d2 : d4;
      tick();
    end
    din4 = 1'b0;
    din2 = 1'b0;
    plen = wlen;
    wlen = 0;
  endtask

  function automatic int count_log(input bit errs);
    int n = 0;
    for (int t = 0; t < plen; t++) n += errs ? int'(e_log[t]) : int'(v_log[t]);
    return n;
  endfunction

  initial begin
    rst = 1'b0; din4 = 1'b0; din2 = 1'b0; rdy4 = 1'b1; rdy2 = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_data", d4, 8'h00);
    check("rst_valid", v4, 1'b0);
    check("rst_busy", b4, 1'b0);
    check("rst_err", e4, 1'b0);
    check("rst_ovr", o4, 1'b0);
    check("rst2_valid", v2, 1'b0);
    check("rst2_busy", b2, 1'b0);
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // 0xA5 with ready high
    add_frame(4, 8'hA5, 1'b0, 1'b0);
    push(1'b0, 4);
    play(1'b0);
    check("a5_busy_c0", b_log[0], 1'b0);
    check("a5_busy_c1", b_log[1], 1'b1);
    check("a5_valid_early", v_log[VC-1], 1'b0);
    check("a5_valid", v_log[VC], 1'b1);
    check("a5_data", d_log[VC], 8'hA5);
    check("a5_valid_drop", v_log[VC+1], 1'b0);
    check("a5_busy_end", b_log[VC], 1'b0);
    check("a5_no_err", count_log(1'b1), 0);
    check("a5_no_ovr", o_log[VC], 1'b0);

    // back-to-back 0x3C, 0xC3 with ready low
    rdy4 = 1'b0;
    add_frame(4, 8'h3C, 1'b0, 1'b0);
    add_frame(4, 8'hC3, 1'b0, 1'b0);
    push(1'b0, 4);
    play(1'b0);
    check("b2b_valid1", v_log[VC], 1'b1);
    check("b2b_data1", d_log[VC], 8'h3C);
    check("b2b_no_ovr1", o_log[VC], 1'b0);
    check("b2b_ovr_early", o_log[4*NB+VC-1], 1'b0);
    check("b2b_ovr", o_log[4*NB+VC], 1'b1);
    check("b2b_hold_data", d_log[4*NB+VC], 8'h3C);
    check("b2b_hold_valid", v_log[4*NB+VC], 1'b1);
    rdy4 = 1'b1;
    tick();
    rdy4 = 1'b0;
    @(negedge clk);
    check("b2b_consumed", v4, 1'b0);
    check("b2b_ovr_sticky", o4, 1'b1);
    tick();
    rdy4 = 1'b1;

    // bad stop bit on 0x81
    add_frame(4, 8'h81, 1'b1, 1'b0);
    push(1'b0, 8);
    play(1'b0);
    check("stop_err_early", e_log[VC-1], 1'b0);
    check("stop_err", e_log[VC], 1'b1);
    check("stop_err_pulse", e_log[VC+1], 1'b0);
    check("stop_no_valid", count_log(1'b0), 0);
    check("stop_data_kept", d_log[VC+1], 8'h3C);

    // one-cycle glitch from idle
    push(1'b1, 1);
    push(1'b0, 8);
    play(1'b0);
    check("glitch_busy", b_log[1], 1'b1);
    check("glitch_idle", b_log[3], 1'b0);
    check("glitch_no_valid", count_log(1'b0), 0);
    check("glitch_no_err", count_log(1'b1), 0);

    // reset after four data bits of 0xFF
    add_frame(4, 8'hFF, 1'b0, 1'b0);
    wlen = 4 * 5;
    play(1'b0);
    check("mid_busy", b_log[19], 1'b1);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_data", d4, 8'h00);
    check("mid_rst_valid", v4, 1'b0);
    check("mid_rst_busy", b4, 1'b0);
    check("mid_rst_err", e4, 1'b0);
    check("mid_rst_ovr", o4, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    add_frame(4, 8'h12, 1'b0, 1'b0);
    push(1'b0, 4);
    play(1'b0);
    check("after_rst_valid", v_log[VC], 1'b1);
    check("after_rst_data", d_log[VC], 8'h12);
    check("after_rst_one_byte", count_log(1'b0), 1);
    check("after_rst_no_ovr", o_log[VC], 1'b0);

    // CLKS_PER_BIT = 2
    add_frame(2, 8'h5A, 1'b0, 1'b0);
    push(1'b0, 4);
    play(1'b1);
    check("cpb2_busy_c1", b_log[1], 1'b1);
    check("cpb2_valid_early", v_log[VC2-1], 1'b0);
    check("cpb2_valid", v_log[VC2], 1'b1);
    check("cpb2_data", d_log[VC2], 8'h5A);
    check("cpb2_valid_drop", v_log[VC2+1], 1'b0);

`ifdef PARITY_EN
    add_frame(4, 8'h07, 1'b0, 1'b0);
    push(1'b0, 4);
    play(1'b0);
    check("par_ok_valid", v_log[VC], 1'b1);
    check("par_ok_data", d_log[VC], 8'h07);
    check("par_ok_no_err", count_log(1'b1), 0);
    add_frame(4, 8'h07, 1'b0, 1'b1);
    push(1'b0, 4);
    play(1'b0);
    check("par_bad_err", e_log[VC], 1'b1);
    check("par_bad_no_valid", count_log(1'b0), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Serial receiver that sits downstream of the parallel-to-serial transmitter. It deserialises the transmitter's framed bit stream back into bytes.
- Frame format, LSB of time first:
  - idle line = 0
  - 1 start bit = 1
  - 8 data bits, MSB first
  - optional parity bit
  - 1 stop bit = 0
- Each bit is held for CLKS_PER_BIT clocks and is sampled at mid-bit.
- Received bytes are presented on a valid/ready output handshake with a one-byte holding register, plus framing-error and overrun flags.

Parameters:
- CLKS_PER_BIT, 4, clocks per serial bit. Legal values 2..255; the bench checks 2 and 4.
- DATA_BITS, 8, data bits per frame. Fixed at 8; any other value is unsupported.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset
- data_in  input  1  serial line from the transmitter
- data_out  output  8  received byte; stable while valid=1
- valid  output  1  data_out holds an unconsumed byte
- ready  input  1  consumer accepts the byte when valid&ready at a rising edge
- busy  output  1  frame reception in progress (state != IDLE)
- frame_err  output  1  one-cycle pulse: stop bit sampled as 1, or (with PARITY_EN) parity mismatch
- overrun  output  1  sticky; set when a good frame completes while valid=1; cleared only by reset

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE; bit counter and clock counter are cleared.
  - Outputs: data_out=0, valid=0, busy=0, frame_err=0, overrun=0.
  - Reset mid-frame aborts the frame and discards all partial data.
- Internal regs: shift[7:0], cnt (clock counter, width ceil(log2(CLKS_PER_BIT))), bitn[3:0].
- IDLE:
  - On data_in=1, go to START with cnt=0.
  - The start bit is detected on its first cycle ("cycle 0").
- START:
  - cnt increments each clock.
  - When cnt==CLKS_PER_BIT/2-1 (i.e. cycle CLKS_PER_BIT/2, mid-bit):
    - data_in=1: go to DATA with cnt=0, bitn=0.
    - data_in=0: treat as a glitch; return to IDLE with no flags.
- DATA:
  - When cnt==CLKS_PER_BIT-1: shift <= {shift[6:0], data_in}, bitn++, cnt=0.
  - After the 8th sample, go to PARITY (PARITY_EN defined) or STOP.
  - Otherwise cnt++.
- STOP:
  - Sample when cnt==CLKS_PER_BIT-1, then go to IDLE in the same edge.
  - data_in=0 and no parity error: frame is good.
    - valid=0 or (valid&ready) this cycle: data_out<=shift, valid<=1.
    - Otherwise: overrun<=1, byte dropped, held data_out unchanged.
  - data_in=1 or parity error: frame_err=1 for exactly one cycle; byte discarded; valid and data_out unchanged.
- Latency, CLKS_PER_BIT=4, no parity:
  - Data bit k is sampled at cycle 2+4(k+1).
  - Stop bit is sampled at cycle 38.
  - valid=1 from cycle 39.
- Handshake:
  - valid falls on the edge where valid&ready=1, unless a new good byte loads at that same edge. In that case valid stays 1 and data_out takes the new byte; this is not an overrun.
  - ready is ignored while valid=0.
- Back-to-back frames: a start bit immediately after the stop bit is detected from IDLE. There are no idle cycles between frames, because STOP is left at the mid-stop sample.
- busy=1 in START/DATA/PARITY/STOP.

Optional Feature:
- Macro PARITY_EN.
- Defined:
  - State PARITY follows DATA and samples one extra bit at cnt==CLKS_PER_BIT-1.
  - Even parity: the XOR of the 8 data bits and the parity bit must be 0.
  - Mismatch raises frame_err in STOP, whatever the stop bit value, and the byte is discarded.
  - Frame length is 11*CLKS_PER_BIT.
- Not defined: no PARITY state; frame length is 10*CLKS_PER_BIT; frame_err reflects the stop bit only.

Test Plan:
- CLKS_PER_BIT=4, ready=1, send 0xA5 -> valid pulses 1 cycle starting cycle 39 after the start edge; data_out=0xA5; frame_err=0; overrun=0.
- ready=0, send 0x3C then 0xC3 back-to-back -> data_out=0x3C and valid held high after the first frame; overrun=1 after the second; data_out still 0x3C. Then ready=1 for one cycle -> valid=0.
- Stop bit driven 1 on byte 0x81 -> frame_err single-cycle pulse at stop sample; valid stays 0.
- 1-cycle glitch (data_in=1 for one clock) in IDLE -> returns to IDLE with busy low within 3 cycles; no valid, no frame_err.
- rst=0 asserted after 4 data bits of 0xFF, then release and send 0x12 -> only 0x12 delivered; all outputs 0 during reset.
- PARITY_EN, send 0x07 with parity bit 1 -> accepted. Same byte with parity bit 0 -> frame_err pulse, valid not asserted.
